// File: rtl/adbg_halt_pkg.sv
// adbg_halt_pkg: shared state encoding and default halt-acknowledge timeout
package adbg_halt_pkg;
  typedef enum logic [2:0] {RUN, HALT_REQ, HALTED, RESUME, STEP} halt_state_e;
  localparam int DEFAULT_HALT_TIMEOUT = 255;
endpackage

// File: rtl/adbg_core_halt_fsm.sv
// adbg_core_halt_fsm: per-core halt/resume/single-step sequencer with registered outputs
module adbg_core_halt_fsm
  import adbg_halt_pkg::*;
#(
  parameter int HALT_TIMEOUT = DEFAULT_HALT_TIMEOUT
) (
  input  logic cpu_clk_i,
  input  logic cpu_rst_i,
  input  logic dbg_stall_i,
  input  logic step_en_i,
  input  logic core_bp_i,
  input  logic core_retire_i,
  input  logic core_halted_i,
  output logic core_halt_req_o,
  output logic bp_o,
  output logic halted_o,
  output logic timeout_o
);
  localparam int CW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(HALT_TIMEOUT);
  halt_state_e state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic bp_nxt, to_nxt;
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    bp_nxt = 1'b0;
    to_nxt = timeout_o;
    case (state)
      RUN: if (core_bp_i || dbg_stall_i) begin
        nxt = HALT_REQ;
        cnt_nxt = '0;
        bp_nxt = core_bp_i;
      end
      HALT_REQ: if (core_halted_i) begin
        nxt = HALTED;
        cnt_nxt = '0;
      end else if (cnt != LIM) begin
        cnt_nxt = cnt + CW'(1);
        to_nxt = timeout_o | (cnt_nxt == LIM);
      end
      HALTED: if (!dbg_stall_i) nxt = step_en_i ? STEP : RESUME;
      RESUME: if (!core_halted_i) nxt = RUN;
      STEP: if (core_retire_i || core_bp_i) begin
        nxt = HALT_REQ;
        cnt_nxt = '0;
        bp_nxt = 1'b1;
      end
      default: nxt = RUN;
    endcase
  end
  // outputs follow the next state so they change on the same edge as the transition
  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      state <= RUN;
      cnt <= '0;
      core_halt_req_o <= 1'b0;
      bp_o <= 1'b0;
      halted_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      core_halt_req_o <= (nxt == HALT_REQ) || (nxt == HALTED);
      bp_o <= bp_nxt;
      halted_o <= nxt == HALTED;
      timeout_o <= to_nxt;
    end
  end
endmodule

// File: rtl/adbg_core_halt_ctrl.sv
// adbg_core_halt_ctrl: one independent halt sequencer per core
module adbg_core_halt_ctrl
  import adbg_halt_pkg::*;
#(
  parameter int NB_CORES = 4,
  parameter int HALT_TIMEOUT = DEFAULT_HALT_TIMEOUT
) (
  input  logic                cpu_clk_i,
  input  logic                cpu_rst_i,
  input  logic [NB_CORES-1:0] dbg_stall_i,
  input  logic [NB_CORES-1:0] step_en_i,
  input  logic [NB_CORES-1:0] core_bp_i,
  input  logic [NB_CORES-1:0] core_retire_i,
  input  logic [NB_CORES-1:0] core_halted_i,
  output logic [NB_CORES-1:0] core_halt_req_o,
  output logic [NB_CORES-1:0] bp_o,
  output logic [NB_CORES-1:0] halted_o,
  output logic [NB_CORES-1:0] timeout_o
);
  for (genvar i = 0; i < NB_CORES; i++) begin : g_core
    adbg_core_halt_fsm #(.HALT_TIMEOUT(HALT_TIMEOUT)) u_fsm (
      .cpu_clk_i(cpu_clk_i),
      .cpu_rst_i(cpu_rst_i),
      .dbg_stall_i(dbg_stall_i[i]),
      .step_en_i(step_en_i[i]),
      .core_bp_i(core_bp_i[i]),
      .core_retire_i(core_retire_i[i]),
      .core_halted_i(core_halted_i[i]),
      .core_halt_req_o(core_halt_req_o[i]),
      .bp_o(bp_o[i]),
      .halted_o(halted_o[i]),
      .timeout_o(timeout_o[i])
    );
  end
endmodule

// File: tb/tb_adbg_core_halt_ctrl.sv
// tb_adbg_core_halt_ctrl: directed and random stimulus scored against a behavioural model
module tb_adbg_core_halt_ctrl;
  localparam int N = 4;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] stall = '0, step = '0, bp = '0, ret = '0, hlt = '0;
  logic [N-1:0] halt_req, bp_out, halted, timeout;
  always #5 clk = ~clk;
  adbg_core_halt_ctrl #(.NB_CORES(N), .HALT_TIMEOUT(T)) dut (
    .cpu_clk_i(clk),
    .cpu_rst_i(rst),
    .dbg_stall_i(stall),
    .step_en_i(step),
    .core_bp_i(bp),
    .core_retire_i(ret),
    .core_halted_i(hlt),
    .core_halt_req_o(halt_req),
    .bp_o(bp_out),
    .halted_o(halted),
    .timeout_o(timeout)
  );
  int total = 0;
  int bad = 0;
  bit mon_on = 0;
  logic [4*N-1:0] q[$];
  bit m_req[N], m_hld[N], m_rel[N], m_stp[N], m_to[N];
  int m_wait[N];
  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_req[i] = 0; m_hld[i] = 0; m_rel[i] = 0; m_stp[i] = 0; m_to[i] = 0; m_wait[i] = 0;
    end
  endtask
  // a core is either running, waiting for an ack, halted, waiting to leave halt, or stepping
  task automatic model_eval(input logic r, output logic [4*N-1:0] e);
    logic [N-1:0] rq, ev, hd, to;
    ev = '0;
    if (r) model_reset();
    else for (int i = 0; i < N; i++) begin
      if (m_stp[i]) begin
        if (ret[i] || bp[i]) begin m_stp[i] = 0; m_req[i] = 1; m_wait[i] = 0; ev[i] = 1; end
      end else if (m_req[i]) begin
        if (hlt[i]) begin m_req[i] = 0; m_hld[i] = 1; end
        else begin m_wait[i]++; if (m_wait[i] >= T) m_to[i] = 1; end
      end else if (m_hld[i]) begin
        if (!stall[i]) begin m_hld[i] = 0; if (step[i]) m_stp[i] = 1; else m_rel[i] = 1; end
      end else if (m_rel[i]) begin
        if (!hlt[i]) m_rel[i] = 0;
      end else if (bp[i] || stall[i]) begin
        m_req[i] = 1; m_wait[i] = 0; ev[i] = bp[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      rq[i] = m_req[i] || m_hld[i];
      hd[i] = m_hld[i];
      to[i] = m_to[i];
    end
    e = {rq, ev, hd, to};
  endtask
  task automatic tick(input logic r, input logic [N-1:0] s, se, b, rt, h);
    logic [4*N-1:0] e;
    rst = r; stall = s; step = se; bp = b; ret = rt; hlt = h;
    model_eval(r, e);
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic areset();
    #1 rst = 1'b1;
    #1;
    chk("async_halt_req", halt_req, '0);
    chk("async_bp", bp_out, '0);
    chk("async_halted", halted, '0);
    chk("async_timeout", timeout, '0);
    model_reset();
    q.push_back('0);
    @(negedge clk);
  endtask
  initial begin
    logic [4*N-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL queue_empty at %0t: got 0 entries want 1", $time);
        end else begin
          e = q.pop_front();
          chk("halt_req", halt_req, e[4*N-1 -: N]);
          chk("bp", bp_out, e[3*N-1 -: N]);
          chk("halted", halted, e[2*N-1 -: N]);
          chk("timeout", timeout, e[N-1:0]);
        end
      end
    end
  end
  initial begin
    logic [N-1:0] rs, rse, rh, rb, rr;
    model_reset();
    @(negedge clk);
    mon_on = 1;
    repeat (2) tick(1, '0, '0, '0, '0, '0);
    repeat (3) tick(0, 4'b0001, '0, '0, '0, '0);
    repeat (3) tick(0, 4'b0001, '0, '0, '0, 4'b0001);
    tick(0, '0, '0, '0, '0, 4'b0001);
    repeat (2) tick(0, '0, '0, '0, '0, '0);
    tick(0, '0, '0, 4'b0100, '0, '0);
    repeat (2) tick(0, '0, '0, '0, '0, 4'b0100);
    repeat (2) tick(0, '0, '0, '0, '0, '0);
    repeat (2) tick(0, 4'b0010, 4'b0010, '0, '0, 4'b0010);
    tick(0, '0, 4'b0010, '0, '0, 4'b0010);
    repeat (2) tick(0, '0, 4'b0010, '0, '0, '0);
    tick(0, '0, 4'b0010, '0, 4'b0010, '0);
    repeat (2) tick(0, '0, 4'b0010, '0, 4'b0010, 4'b0010);
    tick(0, '0, '0, '0, '0, 4'b0010);
    repeat (2) tick(0, '0, '0, '0, '0, '0);
    repeat (7) tick(0, 4'b1000, '0, '0, '0, '0);
    repeat (2) tick(0, 4'b1000, '0, '0, '0, 4'b1000);
    tick(0, '0, '0, '0, '0, 4'b1000);
    repeat (2) tick(0, '0, '0, '0, '0, '0);
    tick(0, 4'b0001, '0, 4'b0001, '0, '0);
    repeat (2) tick(0, 4'b0001, '0, '0, '0, 4'b0001);
    tick(0, 4'b0001, '0, 4'b0001, '0, 4'b0001);
    tick(0, 4'b0001, '0, '0, '0, 4'b0001);
    areset();
    tick(1, 4'b0001, '0, '0, '0, 4'b0001);
    repeat (3) tick(0, 4'b0001, '0, '0, '0, 4'b0001);
    rs = '0; rse = '0; rh = '0;
    repeat (800) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) rs[i] = ~rs[i];
        if ($urandom_range(0, 31) == 0) rse[i] = ~rse[i];
        if ($urandom_range(0, 3) == 0) rh[i] = ~rh[i];
        rb[i] = $urandom_range(0, 7) == 0;
        rr[i] = $urandom_range(0, 5) == 0;
      end
      if ($urandom_range(0, 199) == 0) areset();
      else tick(0, rs, rse, rb, rr, rh);
    end
    mon_on = 0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_leftover: got %0d entries want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
